// File: rtl/uart_rx_fifo_if.sv
// Byte handshake between the UART receiver, the receive FIFO and the host.
// master: receiver/host side, slave: FIFO side.
interface uart_rx_fifo_if #(
  parameter int DATA_W = 8
);
  logic              rx_done;
  logic [DATA_W-1:0] rx_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output rx_done, rx_data, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  rx_done, rx_data, rd_ready,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the 16x-oversampled UART receiver. Takes one byte per
// rx_done high period into a first-word-fall-through FIFO, serves it over a
// valid/ready read port, and keeps a sticky overrun flag plus a saturating
// dropped-byte count.
module uart_rx_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            ovr_clr_i,
  uart_rx_fifo_if.slave   bus,
  output logic [ADDR_W:0] level_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            almost_full_o,
  output logic            overrun_o,
  output logic [7:0]      ovr_count_o
);

  localparam logic [ADDR_W:0] LVL_FULL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_AFULL = (ADDR_W + 1)'(AFULL_LVL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              rx_done_q;
  logic              overrun_q, overrun_d;
  logic [7:0]        ovr_count_q, ovr_count_d;

  logic push, pop, wr_en, drop;
  logic empty, full;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_FULL);

  // One push per rx_done high period: rising edge against the registered level.
  assign push  = bus.rx_done & ~rx_done_q;
  assign pop   = ~empty & bus.rd_ready;
  // A full FIFO still accepts a byte when the host frees a slot in the same cycle.
  assign wr_en = push & ~clr_i & (~full | pop);
  assign drop  = push & ~clr_i & full & ~pop;

  assign bus.rd_valid = ~empty;
  assign bus.rd_data  = empty ? '0 : mem_q[rd_ptr_q];

  assign level_o       = level_q;
  assign empty_o       = empty;
  assign full_o        = full;
  assign almost_full_o = (level_q >= LVL_AFULL);
  assign overrun_o     = overrun_q;
  assign ovr_count_o   = ovr_count_q;

  // Next pointers, level and overrun bookkeeping; clr flushes everything.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overrun_d   = overrun_q;
    ovr_count_d = ovr_count_q;
    if (clr_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overrun_d   = 1'b0;
      ovr_count_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({wr_en, pop})
        2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
        2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
        default: level_d = level_q;
      endcase
      if (ovr_clr_i) begin
        overrun_d   = 1'b0;
        ovr_count_d = '0;
      end
      // A drop in the same cycle as ovr_clr wins and restarts the count at 1.
      if (drop) begin
        overrun_d   = 1'b1;
        ovr_count_d = ovr_clr_i ? 8'd1 :
                      (ovr_count_q == 8'hFF) ? 8'hFF : ovr_count_q + 8'd1;
      end
    end
  end

  // State registers; rx_done_q resets high so a held rx_done never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rx_done_q   <= 1'b1;
      overrun_q   <= 1'b0;
      ovr_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rx_done_q   <= bus.rx_done;
      overrun_q   <= overrun_d;
      ovr_count_q <= ovr_count_d;
    end
  end

  // Storage array, written on accepted pushes only; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: accepted bytes are queued when driven
// and compared as the FIFO presents them; status outputs follow the model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       ovr_clr = 1'b0;
  logic [4:0] level;
  logic       empty, full, afull, overrun;
  logic [7:0] ovr_cnt;

  uart_rx_fifo_if #(.DATA_W(8)) bus ();

  uart_rx_fifo #(
    .DATA_W(8), .DEPTH(DEPTH), .ADDR_W(4), .AFULL_LVL(AFULL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (clr),
    .ovr_clr_i    (ovr_clr),
    .bus          (bus),
    .level_o      (level),
    .empty_o      (empty),
    .full_o       (full),
    .almost_full_o(afull),
    .overrun_o    (overrun),
    .ovr_count_o  (ovr_cnt)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q [$];
  int         exp_ovr = 0;
  bit         exp_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".level"}, 32'(level), 32'(n));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    check({tag, ".afull"}, 32'(afull), 32'(n >= AFULL));
    check({tag, ".ovf"}, 32'(overrun), 32'(exp_ovf));
    check({tag, ".ovr_cnt"}, 32'(ovr_cnt), 32'(exp_ovr));
    check({tag, ".valid"}, 32'(bus.rd_valid), 32'(n != 0));
    check({tag, ".rd_data"}, 32'(bus.rd_data), (n != 0) ? 32'(exp_q[0]) : 32'h0);
  endtask

  // Raise rx_done for 'hold' cycles; optionally pop and/or clear overrun in the push cycle.
  task automatic send(input logic [7:0] b, input int hold, input bit with_pop, input bit with_oclr);
    bit full_before, popping;
    full_before = (exp_q.size() == DEPTH);
    popping = with_pop && (exp_q.size() != 0);
    bus.rx_done = 1'b1;
    bus.rx_data = b;
    bus.rd_ready = with_pop;
    ovr_clr = with_oclr;
    if (popping) begin
      check("pop_with_push", 32'(bus.rd_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (with_oclr) begin
      exp_ovf = 1'b0;
      exp_ovr = 0;
    end
    if (!full_before || popping) exp_q.push_back(b);
    else begin
      exp_ovf = 1'b1;
      exp_ovr = (exp_ovr == 255) ? 255 : exp_ovr + 1;
    end
    tick();
    bus.rd_ready = 1'b0;
    ovr_clr = 1'b0;
    check_status("push");
    repeat (hold - 1) tick();
    if (hold > 1) check_status("hold");
    bus.rx_done = 1'b0;
    tick();
  endtask

  task automatic pop_one(input string tag);
    int n;
    n = 0;
    while (!bus.rd_valid && n < 50) begin
      tick();
      n++;
    end
    if (!bus.rd_valid || exp_q.size() == 0) begin
      check({tag, ".avail"}, 32'(bus.rd_valid), 32'(exp_q.size() != 0));
      return;
    end
    check({tag, ".data"}, 32'(bus.rd_data), 32'(exp_q[0]));
    void'(exp_q.pop_front());
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check_status(tag);
  endtask

  initial begin
    bus.rx_done = 1'b1;
    bus.rx_data = 8'h3C;
    bus.rd_ready = 1'b0;
    #12;
    check_status("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check_status("held_rx_done");
    bus.rx_done = 1'b0;
    tick();

    // 1: long rx_done pulse, rd_ready high while empty
    send(8'hA5, 20, 1'b1, 1'b0);
    pop_one("t1_drain");

    // 2: fill to full, watching almost_full, then drain in order
    for (int i = 1; i <= DEPTH; i++) send(8'(i), 2, 1'b0, 1'b0);
    check("t2_full", 32'(full), 32'h1);
    for (int i = 0; i < DEPTH; i++) pop_one("t2_drain");
    check("t2_empty", 32'(empty), 32'h1);

    // 3: drop while full; 4: push together with pop while full
    for (int i = 1; i <= DEPTH; i++) send(8'(i), 2, 1'b0, 1'b0);
    send(8'h55, 2, 1'b0, 1'b0);
    check("t3_ovr_cnt", 32'(ovr_cnt), 32'h1);
    send(8'h77, 2, 1'b1, 1'b0);
    check("t4_level", 32'(level), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) pop_one("t4_drain");

    // 5: saturation and clearing of the dropped-byte count
    for (int i = 0; i < DEPTH; i++) send(8'(8'h80 + i), 1, 1'b0, 1'b0);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    exp_ovf = 1'b0;
    exp_ovr = 0;
    check_status("t5_oclr0");
    for (int i = 0; i < 260; i++) send(8'(i), 1, 1'b0, 1'b0);
    check("t5_sat", 32'(ovr_cnt), 32'd255);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    exp_ovf = 1'b0;
    exp_ovr = 0;
    check_status("t5_oclr");
    send(8'h99, 1, 1'b0, 1'b1);
    check("t5_setwins", 32'(ovr_cnt), 32'h1);

    // 6: flush, flush with push, then reset mid-read
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_ovr = 0;
    check_status("t6_clr");
    for (int i = 0; i < 5; i++) send(8'(8'hC0 + i), 2, 1'b0, 1'b0);
    clr = 1'b1;
    bus.rx_done = 1'b1;
    bus.rx_data = 8'hEE;
    tick();
    clr = 1'b0;
    exp_q.delete();
    check_status("t6_clr_push");
    bus.rx_done = 1'b0;
    tick();
    check_status("t6_after");
    for (int i = 0; i < 3; i++) send(8'(8'hD0 + i), 1, 1'b0, 1'b0);
    pop_one("t6_read");
    bus.rd_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_ovr = 0;
    check_status("t6_reset");
    bus.rd_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();
    check_status("t6_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
